// File: rtl/ktne_answer_checker.sv
// KTNE answer checker: synchronises and debounces the submit key, then compares the
// slide-switch answer with the generator's pattern and tracks stage/strike progress.
module ktne_answer_checker #(
    parameter int unsigned NUM_SW          = 18,
    parameter int unsigned NUM_STAGES      = 4,
    parameter int unsigned MAX_STRIKES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_submit,
    input  logic [NUM_SW-1:0] sw,
    input  logic [NUM_SW-1:0] expected,
    input  logic              expected_valid,
    output logic              next_req,
    output logic              stage_ok,
    output logic              strike,
    output logic [1:0]        stage,
    output logic [1:0]        strikes,
    output logic              armed,
    output logic              solved,
    output logic              exploded
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StArmed, StCheck, StSolved, StExploded} state_e;

    state_e            state_q, state_d;
    logic              key_meta_q, key_sync_q;
    logic [NUM_SW-1:0] sw_meta_q, sw_sync_q;
    logic              key_db_q, key_db_d;
    logic [CntW-1:0]   db_cnt_q, db_cnt_d;
    logic [NUM_SW-1:0] exp_q, exp_d, ans_q, ans_d;
    logic              next_req_q, next_req_d, stage_ok_q, stage_ok_d, strike_q, strike_d;
    logic [1:0]        stage_q, stage_d, strikes_q, strikes_d;
    logic              armed_q, armed_d, solved_q, solved_d, exploded_q, exploded_d;
    logic              press_evt;

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        key_db_d  = key_db_q;
        db_cnt_d  = '0;
        press_evt = 1'b0;
        if (key_sync_q != key_db_q) begin
            if (db_cnt_q == CntMax) begin
                key_db_d  = key_sync_q;
                press_evt = key_db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        ans_d      = ans_q;
        stage_d    = stage_q;
        strikes_d  = strikes_q;
        next_req_d = 1'b0;
        stage_ok_d = 1'b0;
        strike_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (expected_valid) begin
                    exp_d   = expected;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (press_evt) begin
                    ans_d   = sw_sync_q;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (ans_q == exp_q) begin
                    stage_ok_d = 1'b1;
                    // stage is only 2 bits wide; hold at 3 rather than wrap on the final stage
                    stage_d    = (stage_q == 2'd3) ? 2'd3 : stage_q + 2'd1;
                    if (({1'b0, stage_q} + 3'd1) == 3'(NUM_STAGES)) begin
                        state_d = StSolved;
                    end else begin
                        next_req_d = 1'b1;
                        state_d    = StIdle;
                    end
                end else begin
                    strike_d  = 1'b1;
                    strikes_d = strikes_q + 2'd1;
                    if (({1'b0, strikes_q} + 3'd1) == 3'(MAX_STRIKES)) begin
                        state_d = StExploded;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            StSolved, StExploded: state_d = state_q;
            default: state_d = StIdle;
        endcase
        armed_d    = (state_d == StArmed);
        solved_d   = solved_q | (state_d == StSolved);
        exploded_d = exploded_q | (state_d == StExploded);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_db_q   <= 1'b1;
            db_cnt_q   <= '0;
            state_q    <= StIdle;
            exp_q      <= '0;
            ans_q      <= '0;
            next_req_q <= 1'b0;
            stage_ok_q <= 1'b0;
            strike_q   <= 1'b0;
            stage_q    <= '0;
            strikes_q  <= '0;
            armed_q    <= 1'b0;
            solved_q   <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            key_meta_q <= key_submit;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            key_db_q   <= key_db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            exp_q      <= exp_d;
            ans_q      <= ans_d;
            next_req_q <= next_req_d;
            stage_ok_q <= stage_ok_d;
            strike_q   <= strike_d;
            stage_q    <= stage_d;
            strikes_q  <= strikes_d;
            armed_q    <= armed_d;
            solved_q   <= solved_d;
            exploded_q <= exploded_d;
        end
    end

    assign next_req = next_req_q;
    assign stage_ok = stage_ok_q;
    assign strike   = strike_q;
    assign stage    = stage_q;
    assign strikes  = strikes_q;
    assign armed    = armed_q;
    assign solved   = solved_q;
    assign exploded = exploded_q;

endmodule

// File: tb/tb_ktne_answer_checker.sv
// Bench for ktne_answer_checker: vector table, hand-written corner sequences and a
// randomized game checked against a transaction-level game model.
module tb_ktne_answer_checker;

    localparam int unsigned NSW = 18;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           key_submit = 1'b1;
    logic [NSW-1:0] sw = '0;
    logic [NSW-1:0] expected = '0;
    logic           expected_valid = 1'b0;
    logic           next_req, stage_ok, strike, armed, solved, exploded;
    logic [1:0]     stage, strikes;

    ktne_answer_checker #(
        .NUM_SW(NSW), .NUM_STAGES(4), .MAX_STRIKES(3), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .key_submit(key_submit), .sw(sw),
        .expected(expected), .expected_valid(expected_valid),
        .next_req(next_req), .stage_ok(stage_ok), .strike(strike),
        .stage(stage), .strikes(strikes), .armed(armed),
        .solved(solved), .exploded(exploded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_ok, n_strike, n_next, excl_bad;
    bit gen_mode;  // 1: act as pattern generator on next_req, 0: drop expected_valid
    logic [NSW-1:0] pats [4];
    int gidx;

    typedef struct {
        bit             rst;
        logic [NSW-1:0] exp;
        logic [NSW-1:0] swv;
        int             ok, stk, nxt, stg, strk;
        logic           arm, sol, exl;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stage_ok) n_ok++;
        if (strike) n_strike++;
        if (stage_ok && strike) excl_bad++;
        if (next_req) begin
            n_next++;
            if (gen_mode) begin
                if (gidx < 3) gidx++;
                expected = pats[gidx];
            end else begin
                expected_valid = 1'b0;
            end
        end
    endtask

    task automatic clr_counts();
        n_ok = 0; n_strike = 0; n_next = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        key_submit = 1'b1;
        expected_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        clr_counts();
    endtask

    task automatic press(input logic [NSW-1:0] s);
        clr_counts();
        sw = s;
        repeat (3) tick();
        key_submit = 1'b0;
        repeat (10) tick();
        key_submit = 1'b1;
        repeat (12) tick();
    endtask

    // Game model: stage/strike counters and terminal flags derived from the rules directly.
    int m_stage, m_strikes, m_idx, e_ok, e_stk, e_nxt;
    bit m_solved, m_exploded;

    task automatic model_press(input logic [NSW-1:0] s);
        e_ok = 0; e_stk = 0; e_nxt = 0;
        if (!m_solved && !m_exploded) begin
            if (s == pats[m_idx]) begin
                m_stage++;
                e_ok = 1;
                if (m_stage == 4) m_solved = 1;
                else begin
                    e_nxt = 1;
                    m_idx++;
                end
            end else begin
                m_strikes++;
                e_stk = 1;
                if (m_strikes == 3) m_exploded = 1;
            end
        end
    endtask

    initial begin
        logic [NSW-1:0] s;
        bit stopped;
        excl_bad = 0;
        clr_counts();
        gen_mode = 1'b0;
        gidx = 0;

        // Outputs while reset is held
        repeat (3) tick();
        check("rst_next_req", 32'(next_req), 0);
        check("rst_stage_ok", 32'(stage_ok), 0);
        check("rst_strike", 32'(strike), 0);
        check("rst_stage", 32'(stage), 0);
        check("rst_strikes", 32'(strikes), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_solved", 32'(solved), 0);
        check("rst_exploded", 32'(exploded), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Vector table: one solving game, then one exploding game
        vecs[0] = '{1'b1, 18'h00001, 18'h00001, 1, 0, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 18'h00010, 18'h00002, 0, 1, 0, 1, 1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 18'h00010, 18'h00010, 1, 0, 1, 2, 1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 18'h00100, 18'h00100, 1, 0, 1, 3, 1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 18'h01000, 18'h01000, 1, 0, 0, 3, 1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 18'h01000, 18'h01000, 0, 0, 0, 3, 1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 18'h3ffff, 18'h00000, 0, 1, 0, 0, 1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 18'h3ffff, 18'h00001, 0, 1, 0, 0, 2, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 18'h3ffff, 18'h12345, 0, 1, 0, 0, 3, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 18'h3ffff, 18'h3ffff, 0, 0, 0, 0, 3, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            expected = vecs[i].exp;
            expected_valid = 1'b1;
            repeat (2) tick();
            press(vecs[i].swv);
            check($sformatf("vec%0d_stage_ok", i), n_ok, vecs[i].ok);
            check($sformatf("vec%0d_strike", i), n_strike, vecs[i].stk);
            check($sformatf("vec%0d_next_req", i), n_next, vecs[i].nxt);
            check($sformatf("vec%0d_stage", i), 32'(stage), vecs[i].stg);
            check($sformatf("vec%0d_strikes", i), 32'(strikes), vecs[i].strk);
            check($sformatf("vec%0d_armed", i), 32'(armed), 32'(vecs[i].arm));
            check($sformatf("vec%0d_solved", i), 32'(solved), 32'(vecs[i].sol));
            check($sformatf("vec%0d_exploded", i), 32'(exploded), 32'(vecs[i].exl));
        end

        // Bouncy key then a long hold: exactly one evaluation
        do_reset();
        gen_mode = 1'b1;
        pats[0] = 18'h00001; pats[1] = 18'h00010; pats[2] = 18'h00100; pats[3] = 18'h01000;
        gidx = 0;
        expected = pats[0];
        expected_valid = 1'b1;
        sw = 18'h00001;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            key_submit = i[0] ? 1'b1 : 1'b0;
            repeat (2) tick();
        end
        key_submit = 1'b0;
        repeat (10) tick();
        key_submit = 1'b1;
        repeat (12) tick();
        check("bounce_stage_ok", n_ok, 1);
        check("bounce_strike", n_strike, 0);
        check("bounce_stage", 32'(stage), 1);

        // Three-cycle glitch: no evaluation
        clr_counts();
        key_submit = 1'b0;
        repeat (3) tick();
        key_submit = 1'b1;
        repeat (15) tick();
        check("glitch_pulses", n_ok + n_strike, 0);
        check("glitch_armed", 32'(armed), 1);

        // Changing expected while armed does not disturb the latched pattern
        expected = 18'h3ffff;
        press(18'h00010);
        check("latched_stage_ok", n_ok, 1);
        check("latched_stage", 32'(stage), 2);

        // Reset asserted while the check is pending
        clr_counts();
        expected_valid = 1'b1;
        repeat (3) tick();
        key_submit = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 40 && !stopped; i++) begin
            tick();
            if (!armed) stopped = 1'b1;
        end
        check("midrst_reached_check", 32'(stopped), 1);
        reset = 1'b0;
        key_submit = 1'b1;
        expected_valid = 1'b0;
        repeat (3) tick();
        check("midrst_stage", 32'(stage), 0);
        check("midrst_next_req", 32'(next_req), 0);
        reset = 1'b1;
        repeat (10) tick();
        check("midrst_pulses", n_ok + n_strike + n_next, 0);
        check("midrst_idle_unarmed", 32'(armed), 0);
        expected_valid = 1'b1;
        repeat (2) tick();
        check("midrst_rearm", 32'(armed), 1);

        // Randomized games against the model
        for (int g = 0; g < 6; g++) begin
            do_reset();
            gen_mode = 1'b1;
            for (int k = 0; k < 4; k++) pats[k] = NSW'($urandom);
            gidx = 0;
            expected = pats[0];
            expected_valid = 1'b1;
            m_stage = 0; m_strikes = 0; m_idx = 0; m_solved = 0; m_exploded = 0;
            for (int p = 0; p < 9; p++) begin
                if ($urandom_range(0, 2) != 0 && !m_solved && !m_exploded) s = pats[m_idx];
                else s = NSW'($urandom);
                model_press(s);
                press(s);
                check("rnd_stage_ok", n_ok, e_ok);
                check("rnd_strike", n_strike, e_stk);
                check("rnd_next_req", n_next, e_nxt);
                check("rnd_stage", 32'(stage), (m_stage > 3) ? 3 : m_stage);
                check("rnd_strikes", 32'(strikes), m_strikes);
                check("rnd_solved", 32'(solved), 32'(m_solved));
                check("rnd_exploded", 32'(exploded), 32'(m_exploded));
                check("rnd_armed", 32'(armed), 32'(!(m_solved || m_exploded)));
            end
        end

        check("stage_ok_strike_exclusive", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
